// File: rtl/pp_pipeline_accel_scalar_fanout_if.sv
// pp_pipeline_accel_scalar_fanout_if: control handshake plus input/output FIFO bus for the scalar fanout
//   ap_start/ap_continue -> block; ap_done/ap_idle/ap_ready <- block
//   in_dout/in_empty_n -> block, in_read <- block (one lane per channel)
//   out_full_n -> block, out_din/out_write <- block (one lane per target k = c*NUM_OUT+o)
//   range_err <- block (sticky per-channel flag)
interface pp_pipeline_accel_scalar_fanout_if #(
    parameter int NUM_CH  = 2,
    parameter int NUM_OUT = 2,
    parameter int DATA_W  = 11
);
    logic                               ap_start;
    logic                               ap_done;
    logic                               ap_continue;
    logic                               ap_idle;
    logic                               ap_ready;
    logic [NUM_CH*DATA_W-1:0]           in_dout;
    logic [NUM_CH-1:0]                  in_empty_n;
    logic [NUM_CH-1:0]                  in_read;
    logic [NUM_CH*NUM_OUT*DATA_W-1:0]   out_din;
    logic [NUM_CH*NUM_OUT-1:0]          out_full_n;
    logic [NUM_CH*NUM_OUT-1:0]          out_write;
    logic [NUM_CH-1:0]                  range_err;
    modport slave (
        input  ap_start, ap_continue, in_dout, in_empty_n, out_full_n,
        output ap_done, ap_idle, ap_ready, in_read, out_din, out_write, range_err
    );
    modport master (
        output ap_start, ap_continue, in_dout, in_empty_n, out_full_n,
        input  ap_done, ap_idle, ap_ready, in_read, out_din, out_write, range_err
    );
endinterface

// File: rtl/pp_pipeline_accel_scalar_fanout.sv
// pp_pipeline_accel_scalar_fanout: pops one scalar per channel per invocation and fans it out to NUM_OUT FIFOs
//   ap_clk, ap_rst_n : clock, asynchronous active-low reset
//   bus (slave)      : ap_ctrl_hs handshake, input FIFOs, output FIFOs, sticky range_err
module pp_pipeline_accel_scalar_fanout #(
    parameter int NUM_CH  = 2,
    parameter int NUM_OUT = 2,
    parameter int DATA_W  = 11,
    parameter int MAX_VAL = 1920
) (
    input logic                                  ap_clk,
    input logic                                  ap_rst_n,
    pp_pipeline_accel_scalar_fanout_if.slave     bus
);
    localparam int NT = NUM_CH * NUM_OUT;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t                         state;
    logic [NUM_CH-1:0]              cap;
    logic [NT-1:0]                  wr;
    logic [NUM_CH-1:0][DATA_W-1:0]  hold;
    logic [NUM_CH-1:0]              bad;
    logic [NT-1:0]                  cap_t;
    logic                           run;
    assign run = (state == RUN);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DATA_W-1:0] v;
        assign v      = bus.in_dout[c*DATA_W +: DATA_W];
        assign bad[c] = (v == '0) || (v > DATA_W'(MAX_VAL));
    end
    // each target follows the capture flag of its owning channel
    for (genvar k = 0; k < NT; k++) begin : g_tgt
        assign cap_t[k]                         = cap[k/NUM_OUT];
        assign bus.out_din[k*DATA_W +: DATA_W]  = hold[k/NUM_OUT];
    end
    assign bus.in_read   = {NUM_CH{run}} & bus.in_empty_n & ~cap;
    assign bus.out_write = {NT{run}} & cap_t & ~wr & bus.out_full_n;
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state         <= IDLE;
            cap           <= '0;
            wr            <= '0;
            hold          <= '0;
            bus.range_err <= '0;
            bus.ap_done   <= 1'b0;
            bus.ap_ready  <= 1'b0;
            bus.ap_idle   <= 1'b1;
        end else begin
            case (state)
                IDLE: if (bus.ap_start) begin
                    state         <= RUN;
                    cap           <= '0;
                    wr            <= '0;
                    bus.range_err <= '0;
                    bus.ap_idle   <= 1'b0;
                end
                RUN: begin
                    for (int c = 0; c < NUM_CH; c++)
                        if (bus.in_read[c]) begin
                            hold[c]          <= bus.in_dout[c*DATA_W +: DATA_W];
                            cap[c]           <= 1'b1;
                            bus.range_err[c] <= bad[c];
                        end
                    wr <= wr | bus.out_write;
                    // finish as soon as the writes landing on this edge complete the set
                    if (&(wr | bus.out_write)) begin
                        state        <= DONE;
                        bus.ap_done  <= 1'b1;
                        bus.ap_ready <= 1'b1;
                    end
                end
                DONE: begin
                    bus.ap_ready <= 1'b0;
                    if (bus.ap_continue) begin
                        state       <= IDLE;
                        bus.ap_done <= 1'b0;
                        bus.ap_idle <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    // a target already marked written must never be pushed again in the same invocation
    a_single_write: assert property (@(posedge ap_clk) disable iff (!ap_rst_n) (bus.out_write & wr) == '0);
endmodule

// File: doc/pp_pipeline_accel_scalar_fanout.md
Name: pp_pipeline_accel_scalar_fanout

Overview:
- Parametrised, multi-channel successor to the entry-process scalar forwarder in the pp_pipeline_accel dataflow region.
- Reads one scalar per channel per invocation (rows, cols, stride, ...) from input FIFOs and fans each value out to NUM_OUT consumer FIFOs.
- Unlike the all-or-nothing forwarder, each channel and each output makes independent progress via holding registers and per-target written flags.
- Adds range checking with sticky error flags. Uses the ap_ctrl_hs start/done/continue handshake.

Parameters:
- NUM_CH, 2, number of scalar channels (1..8)
- NUM_OUT, 2, consumer FIFOs per channel (1..4)
- DATA_W, 11, scalar width in bits
- MAX_VAL, 1920, largest legal value; 0 and values > MAX_VAL are flagged

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  asynchronous active-low reset
- ap_start  in  1  invocation request
- ap_done  out  1  invocation complete; held until ap_continue
- ap_continue  in  1  acknowledges done
- ap_idle  out  1  block in IDLE
- ap_ready  out  1  one-cycle pulse, ready for next start
- in_dout  in  NUM_CH*DATA_W  input FIFO data; channel c at bits [c*DATA_W +: DATA_W]
- in_empty_n  in  NUM_CH  input FIFO not empty
- in_read  out  NUM_CH  input FIFO pop
- out_din  out  NUM_CH*NUM_OUT*DATA_W  output data; target k = c*NUM_OUT+o
- out_full_n  in  NUM_CH*NUM_OUT  output FIFO not full
- out_write  out  NUM_CH*NUM_OUT  output FIFO push
- range_err  out  NUM_CH  sticky per-channel out-of-range flag

Behaviour:
- Reset (async assert, sync release): state=IDLE; cap, wr, hold regs, range_err all 0. Outputs at reset: ap_done=0, ap_ready=0, ap_idle=1, in_read=0, out_write=0.
- States: IDLE, RUN, DONE.
- IDLE: ap_idle=1. If ap_start=1, then on the next edge go to RUN and clear cap, wr and range_err.
- RUN, reads: in_read[c] = in_empty_n[c] & ~cap[c], asserted combinationally. On that edge hold[c]<=in_dout[c], cap[c]<=1, and range_err[c]<=(value==0 | value>MAX_VAL).
- RUN, writes: out_write[k] = cap[c] & ~wr[k] & out_full_n[k]. On that edge wr[k]<=1.
  - out_din[k]=hold[c] at all times; there is no bypass.
  - Each channel is popped exactly once per invocation; each target is written exactly once.
- RUN exit: when every wr bit is set after the current edge (including writes in this cycle), go to DONE.
- Minimum latency: start accepted at cycle 0; reads at cycle 1; writes at cycle 2; ap_done=1 from cycle 3.
- DONE: ap_done=1 and ap_ready=1 for the first DONE cycle only. ap_continue=1 goes to IDLE on the next edge; ap_start in the same cycle is ignored until IDLE.
- Back-pressure: a full target stalls only itself. The other targets and channels proceed. Empty inputs stall only their channel.
- Values are forwarded unmodified regardless of range_err.
- range_err holds its value through DONE and IDLE until the next start is accepted.
- ap_start dropping mid-RUN has no effect; the invocation completes.
- Reset mid-RUN: all state is discarded. Data already popped is lost, and partial writes are not repeated.
- RTL includes an assertion that out_write[k] never fires twice per invocation.

Test Plan:
- NUM_CH=2, NUM_OUT=2, all FIFOs ready, in={1080,1920}, start pulse → in_read=2'b11 at cycle 1; out_write=4'b1111 at cycle 2 with din {1080,1080,1920,1920}; ap_done=1 and ap_ready pulse at cycle 3; range_err=0.
- out_full_n[3]=0 for 5 cycles, others ready → targets 0-2 written at cycle 2; target 3 written the cycle after full_n rises; ap_done exactly one cycle later.
- in_empty_n[1] low for 4 cycles → channel 0 completes; channel 1 pops once after empty_n rises; no duplicate reads on either channel.
- in={0,2000} → range_err=2'b11 sticky through DONE; data forwarded as 0 and 2000; cleared on next accepted start.
- Hold ap_continue=0 for 3 cycles in DONE → ap_done stays 1, ap_ready pulses once, no reads or writes; continue=1 → IDLE next cycle, ap_idle=1.
- Assert ap_rst_n=0 mid-RUN after channel 0 captured → all outputs at reset values immediately; the next invocation pops both channels afresh.
